// File: rtl/arashi_thread_arbiter_if.sv
// Cache-side and consumer-side signal bundle for the thread arbiter.
interface arashi_thread_arbiter_if #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned NUM_THREADS = 4
);
  localparam int unsigned TID_WIDTH = $clog2(NUM_THREADS);

  logic [NUM_THREADS-1:0]            avail;
  logic [NUM_THREADS-1:0]            r_ena;
  logic [NUM_THREADS*DATA_WIDTH-1:0] data_in;
  logic                              out_valid;
  logic                              out_ready;
  logic [DATA_WIDTH-1:0]             out_data;
  logic [TID_WIDTH-1:0]              out_tid;

  // Arbiter side
  modport master (
    input  avail, data_in, out_ready,
    output r_ena, out_valid, out_data, out_tid
  );

  // Caches + consumer side
  modport slave (
    output avail, data_in, out_ready,
    input  r_ena, out_valid, out_data, out_tid
  );
endinterface

// File: rtl/arashi_thread_arbiter.sv
// Round-robin read arbiter over NUM_THREADS thread caches with a 4-entry
// tagged output queue. Optional stall counter enabled by ARASHI_ARB_STALL_CNT_EN.
module arashi_thread_arbiter #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned NUM_THREADS = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
`ifdef ARASHI_ARB_STALL_CNT_EN
  output logic [15:0]             stall_cnt,
`endif
  arashi_thread_arbiter_if.master bus
);
  localparam int unsigned TID_WIDTH = $clog2(NUM_THREADS);
  localparam int unsigned Q_DEPTH   = 4;
  localparam int unsigned PTR_W     = 2;
  localparam int unsigned OCC_W     = 3;
  localparam int unsigned PEND_W    = 2;

  logic [NUM_THREADS-1:0] r_rd_ena;
  logic [TID_WIDTH-1:0]   r_rr_ptr;
  logic                   r_s1_vld;
  logic                   r_s2_vld;
  logic [TID_WIDTH-1:0]   r_s1_tid;
  logic [TID_WIDTH-1:0]   r_s2_tid;
  logic [DATA_WIDTH-1:0]  r_q_data [Q_DEPTH];
  logic [TID_WIDTH-1:0]   r_q_tid  [Q_DEPTH];
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [OCC_W-1:0]       r_occ;
  logic [PEND_W-1:0]      r_pend;
  logic                   r_head_vld;
  logic [DATA_WIDTH-1:0]  r_head_data;
  logic [TID_WIDTH-1:0]   r_head_tid;

  logic                   w_found;
  logic [TID_WIDTH-1:0]   w_winner;
  logic                   w_issue;
  logic [TID_WIDTH-1:0]   w_rr_nxt;
  logic                   w_push;
  logic                   w_pop;
  logic [DATA_WIDTH-1:0]  w_push_data;
  logic [OCC_W-1:0]       w_occ_nxt;
  logic [PTR_W-1:0]       w_rd_ptr_nxt;
  logic [DATA_WIDTH-1:0]  w_head_data_nxt;
  logic [TID_WIDTH-1:0]   w_head_tid_nxt;
  logic [PEND_W-1:0]      w_pend_nxt;

  assign bus.r_ena     = r_rd_ena;
  assign bus.out_valid = r_head_vld;
  assign bus.out_data  = r_head_data;
  assign bus.out_tid   = r_head_tid;

  // Pick the available thread nearest to rr_ptr (wrapping) and gate it by queue credit
  always_comb begin
    int unsigned v_dist;
    int unsigned v_best;
    v_dist   = 0;
    v_best   = NUM_THREADS;
    w_found  = 1'b0;
    w_winner = '0;
    for (int unsigned i = 0; i < NUM_THREADS; i++) begin
      v_dist = (i + NUM_THREADS - 32'(r_rr_ptr)) % NUM_THREADS;
      if (bus.avail[i] && (v_dist < v_best)) begin
        v_best   = v_dist;
        w_winner = TID_WIDTH'(i);
        w_found  = 1'b1;
      end
    end
    w_issue  = w_found && ((4'(r_occ) + 4'(r_pend)) < 4'(Q_DEPTH));
    w_rr_nxt = (w_winner == TID_WIDTH'(NUM_THREADS - 1)) ? '0 : w_winner + 1'b1;
  end

  // Return-path capture, queue pointer/occupancy and next-head selection
  always_comb begin
    w_push      = r_s2_vld;
    w_pop       = r_head_vld && bus.out_ready;
    w_push_data = '0;
    for (int unsigned t = 0; t < NUM_THREADS; t++) begin
      if (r_s2_tid == TID_WIDTH'(t)) w_push_data = bus.data_in[t*DATA_WIDTH +: DATA_WIDTH];
    end
    w_occ_nxt       = r_occ + OCC_W'(w_push) - OCC_W'(w_pop);
    w_rd_ptr_nxt    = r_rd_ptr + PTR_W'(w_pop);
    w_head_data_nxt = r_head_data;
    w_head_tid_nxt  = r_head_tid;
    if (w_occ_nxt != '0) begin
      if (w_push && (r_wr_ptr == w_rd_ptr_nxt)) begin
        w_head_data_nxt = w_push_data;
        w_head_tid_nxt  = r_s2_tid;
      end else begin
        w_head_data_nxt = r_q_data[w_rd_ptr_nxt];
        w_head_tid_nxt  = r_q_tid[w_rd_ptr_nxt];
      end
    end
    case ({w_issue, w_push})
      2'b10:   w_pend_nxt = r_pend + PEND_W'(1);
      2'b01:   w_pend_nxt = r_pend - PEND_W'(1);
      default: w_pend_nxt = r_pend;
    endcase
  end

  // Grant register, return shift, queue storage and head; reset drops in-flight reads
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rd_ena    <= '0;
      r_rr_ptr    <= '0;
      r_s1_vld    <= 1'b0;
      r_s2_vld    <= 1'b0;
      r_s1_tid    <= '0;
      r_s2_tid    <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_occ       <= '0;
      r_pend      <= '0;
      r_head_vld  <= 1'b0;
      r_head_data <= '0;
      r_head_tid  <= '0;
      for (int unsigned i = 0; i < Q_DEPTH; i++) begin
        r_q_data[i] <= '0;
        r_q_tid[i]  <= '0;
      end
    end else begin
      assert (!(w_push && (r_occ == OCC_W'(Q_DEPTH))));
      r_rd_ena <= w_issue ? (NUM_THREADS'(1) << w_winner) : '0;
      if (w_issue) r_rr_ptr <= w_rr_nxt;
      r_s1_vld <= w_issue;
      r_s1_tid <= w_winner;
      r_s2_vld <= r_s1_vld;
      r_s2_tid <= r_s1_tid;
      if (w_push) begin
        r_q_data[r_wr_ptr] <= w_push_data;
        r_q_tid[r_wr_ptr]  <= r_s2_tid;
        r_wr_ptr           <= r_wr_ptr + PTR_W'(1);
      end
      r_rd_ptr    <= w_rd_ptr_nxt;
      r_occ       <= w_occ_nxt;
      r_pend      <= w_pend_nxt;
      r_head_vld  <= (w_occ_nxt != '0);
      r_head_data <= w_head_data_nxt;
      r_head_tid  <= w_head_tid_nxt;
    end
  end

`ifdef ARASHI_ARB_STALL_CNT_EN
  logic [15:0] r_stall_cnt;
  assign stall_cnt = r_stall_cnt;

  // Saturating count of cycles where the head is offered but not taken
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_stall_cnt <= '0;
    end else if (r_head_vld && !bus.out_ready && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/arashi_thread_arbiter.md
Name: arashi_thread_arbiter

Overview:
- Round-robin read arbiter directly downstream of NUM_THREADS per-thread caches.
- Each cycle it samples the caches' avail vector and issues at most one registered one-hot read enable.
- It captures the returned word, 1 cycle after the read enable, into a 4-entry output queue tagged with the thread id.
- It presents that queue to the consumer with a valid/ready handshake.

Parameters:
- DATA_WIDTH, 32, width of one thread-cache word.
- NUM_THREADS, 4, number of thread caches arbitrated; legal range 2..16.
- TID_WIDTH, $clog2(NUM_THREADS), thread id width; derived, not to be overridden.

Ports:
- clk  input  1  clock.
- rstn  input  1  synchronous active-low reset.
- avail  input  NUM_THREADS  per-thread "data readable next cycle" flag from each cache.
- r_ena  output  NUM_THREADS  one-hot (or zero) read enable to the caches; registered.
- data_in  input  NUM_THREADS*DATA_WIDTH  flattened cache data_out buses; thread i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- out_valid  output  1  queue head valid.
- out_ready  input  1  consumer accepts head this cycle.
- out_data  output  DATA_WIDTH  queue head data.
- out_tid  output  TID_WIDTH  thread id of queue head.

Behaviour:
- Reset: rstn sampled on clk only, active low. Synchronous reset applies to all state.
  - r_ena=0, out_valid=0, out_data=0, out_tid=0.
  - Queue empty; pending count 0; round-robin pointer rr_ptr=0.
- No combinational path from avail to r_ena.
  - Mandatory: cache avail depends combinationally on r_ena.
  - The grant is computed from avail in cycle t and drives r_ena in cycle t+1.
- Grant rule in cycle t:
  - Candidates are threads with avail[i]=1, searched starting at rr_ptr, wrapping modulo NUM_THREADS.
  - Issue is permitted only when occupancy + pending < 4.
  - pending = number of reads issued whose data has not yet been written into the queue; range 0..2.
  - On issue: r_ena <= onehot(winner), rr_ptr <= winner+1 mod NUM_THREADS.
  - Otherwise: r_ena <= 0 and rr_ptr unchanged.
- Same thread may win consecutive cycles only when no other thread is available. Cache avail already accounts for the in-flight r_ena.
- Return path:
  - r_ena[i] high in cycle t+1 means the cache returns data in cycle t+2.
  - The arbiter keeps a 2-stage grant shift (valid + tid).
  - In cycle t+2 it writes data_in slice[tid] and tid into the queue tail at the clock edge ending t+2.
  - Latency: avail high at t, r_ena at t+1, out_valid at t+3 (earliest).
- Queue: 4 entries, 2-bit read and write pointers with natural wrap, 3-bit occupancy 0..4.
  - Head is registered state. out_data/out_tid reflect the head entry; hold last value while empty.
  - Pop when out_valid && out_ready.
  - Push and pop in the same cycle: occupancy unchanged, both pointers advance.
  - Push into a full queue is structurally impossible because of the credit rule. Assert it in simulation.
- Pending count:
  - +1 on grant issue.
  - -1 on queue write.
  - Both in the same cycle: unchanged.
- out_ready high with queue empty: no effect.
- out_ready low: head held stable, out_valid remains 1.
- Reset mid-operation: in-flight reads are discarded. The data from any cache read already launched is dropped, not queued.

Optional Feature:
- Macro ARASHI_ARB_STALL_CNT_EN.
- Defined:
  - Adds output port stall_cnt [15:0], reset 0.
  - Increments each cycle out_valid=1 && out_ready=0; saturates at 16'hFFFF.
  - Never clears except by reset.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset with all inputs 0 for 3 cycles -> r_ena=0, out_valid=0, out_data=0, out_tid=0 throughout.
- Only avail[2]=1 at t, data_in slice2=32'hA5A5_0001 at t+2, out_ready=1 -> r_ena=4'b0100 at t+1, out_valid=1 at t+3 with out_data=32'hA5A5_0001, out_tid=2.
- avail=4'b1111 held, out_ready=1 -> grants rotate 0,1,2,3,0 on consecutive cycles; one queue push per cycle after 2-cycle fill; no bubbles.
- avail=4'b0001 held, out_ready=0 -> exactly 4 grants issued, then r_ena stays 0. out_valid=1 with tid 0 held. Raising out_ready drains 4 words in order; grants resume 1 cycle after the first pop.
- Grant issued at t, rstn=0 at t+1 -> queue empty, pending=0, out_valid=0 after reset; the returning data word is not queued.
- ARASHI_ARB_STALL_CNT_EN defined, out_valid=1, out_ready=0 for 70000 cycles -> stall_cnt=16'hFFFF and holds. Undefined build compiles without the port.
